// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter/receiver state encoding and defaults
package uart_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, PARITY, STOP} tx_state_t;
  localparam int CLKS_PER_BIT_DEF = 16;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read port between the transmitter (master) and the FIFO (slave)
interface fifo_uart_tx_if #(parameter int DATA_WIDTH = 8) ();
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
  modport slave (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [W-1:0] cnt;
  assign bit_end = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clear || bit_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO and serialises each byte as a UART frame
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] last_bit = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] last_stop = BW'(STOP_BITS - 1);
  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity;
  logic [BW-1:0]         bit_cnt;
  logic                  bit_end;
  logic                  clear;
  // the baud counter is held at 0 until the start bit so every frame begins on a fresh bit
  assign clear = state inside {IDLE, FETCH, LATCH};
  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .rst(rst), .clear(clear), .bit_end(bit_end)
  );
  // outputs are registered alongside the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      tx              <= 1'b1;
      fifo.fifo_rd_en <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      shift_reg       <= '0;
      parity          <= 1'b0;
      bit_cnt         <= '0;
    end else begin
      fifo.fifo_rd_en <= 1'b0;
      frame_done      <= 1'b0;
      case (state)
        IDLE: if (!fifo.fifo_empty) begin
          state           <= FETCH;
          fifo.fifo_rd_en <= 1'b1;
          busy            <= 1'b1;
        end
        FETCH: state <= LATCH;
        LATCH: begin
          shift_reg <= fifo.fifo_data;
          parity    <= ^fifo.fifo_data;
          state     <= START;
          tx        <= 1'b0;
        end
        START: if (bit_end) begin
          state   <= DATA;
          tx      <= shift_reg[0];
          bit_cnt <= '0;
        end
        DATA: if (bit_end) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= bit_cnt + 1'b1;
          tx        <= shift_reg[1];
          if (bit_cnt == last_bit) begin
            state   <= PARITY_EN != 0 ? PARITY : STOP;
            tx      <= PARITY_EN != 0 ? parity : 1'b1;
            bit_cnt <= '0;
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: if (bit_end) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == last_stop) begin
            bit_cnt    <= '0;
            frame_done <= 1'b1;
            if (!fifo.fifo_empty) begin
              state           <= FETCH;
              fifo.fifo_rd_en <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of the FIFO-fed UART transmitter
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_a, busy_a, fd_a, tx_b, busy_b, fd_b;
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  logic [3:0] wr_a = '0, rd_a = '0, wr_b = '0, rd_b = '0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  int n_chk = 0, n_err = 0, viol = 0;
  int rd_cnt_a = 0, fd_cnt_a = 0, rd_cnt_b = 0, fd_cnt_b = 0;
  fifo_uart_tx_if #(.DATA_WIDTH(8)) ifa ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) ifb ();
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .fifo(ifa), .tx(tx_a), .busy(busy_a), .frame_done(fd_a)
  );
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .fifo(ifb), .tx(tx_b), .busy(busy_b), .frame_done(fd_b)
  );
  always #5 clk = ~clk;
  // FIFO models: registered read data, valid only in the cycle after the read enable
  assign ifa.fifo_empty = rd_a == wr_a;
  assign ifb.fifo_empty = rd_b == wr_b;
  always @(posedge clk) begin
    ifa.fifo_data <= ifa.fifo_rd_en ? mem_a[rd_a] : 8'hEE;
    ifb.fifo_data <= ifb.fifo_rd_en ? mem_b[rd_b] : 8'hEE;
    if (ifa.fifo_rd_en) rd_a <= rd_a + 1'b1;
    if (ifb.fifo_rd_en) rd_b <= rd_b + 1'b1;
  end
  always @(posedge clk) begin
    if (ifa.fifo_rd_en) rd_cnt_a++;
    if (ifb.fifo_rd_en) rd_cnt_b++;
    if (fd_a) fd_cnt_a++;
    if (fd_b) fd_cnt_b++;
    if ((ifa.fifo_rd_en && (ifa.fifo_empty || prev_a)) || (ifb.fifo_rd_en && (ifb.fifo_empty || prev_b))) viol++;
    prev_a = ifa.fifo_rd_en;
    prev_b = ifb.fifo_rd_en;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input bit which, input logic [7:0] b);
    if (which) begin
      mem_b[wr_b] = b;
      wr_b = wr_b + 1'b1;
    end else begin
      mem_a[wr_a] = b;
      wr_a = wr_a + 1'b1;
    end
  endtask
  function automatic logic [63:0] wave(input logic [7:0] b, input int pe, input int sb);
    logic [63:0] w;
    logic [11:0] bits;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    if (pe != 0) bits[9] = ^b;
    w = '0;
    for (int i = 0; i < (9 + pe + sb) * 4; i++) w[i] = bits[i / 4];
    return w;
  endfunction
  task automatic wait_low(input bit which, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((which ? tx_b : tx_a) !== 1'b0 && k < 200);
  endtask
  task automatic send_frame(input string tag, input bit which, input logic [7:0] b, input int gap, input logic busy_after);
    int k, pe, sb, n;
    logic [63:0] w;
    logic [7:0] dec;
    logic all_busy;
    pe = which ? 1 : 0;
    sb = which ? 2 : 1;
    n = (9 + pe + sb) * 4;
    wait_low(which, k);
    check({tag, "_gap"}, 64'(k), 64'(gap));
    w = '0;
    all_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      w[i] = which ? tx_b : tx_a;
      all_busy &= which ? busy_b : busy_a;
    end
    check({tag, "_wave"}, w, wave(b, pe, sb));
    for (int i = 0; i < 8; i++) dec[i] = w[4 * i + 6];
    check({tag, "_dec"}, 64'(dec), 64'(b));
    check({tag, "_busy"}, 64'(all_busy), 64'(1));
    @(negedge clk);
    check({tag, "_done"}, 64'(which ? {fd_b, busy_b} : {fd_a, busy_a}), 64'({1'b1, busy_after}));
  endtask
  initial begin
    int k;
    logic bad;
    push(0, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out", 64'({tx_a, ifa.fifo_rd_en, busy_a, fd_a}), 64'(4'b1000));
    end
    rst = 1'b0;
    @(negedge clk);
    check("rd_after_rst", 64'(ifa.fifo_rd_en), 64'(1));
    send_frame("a5", 0, 8'hA5, 2, 1'b0);
    repeat (2) @(negedge clk);
    check("a5_rd_cnt", 64'(rd_cnt_a), 64'(1));
    check("a5_fd_cnt", 64'(fd_cnt_a), 64'(1));
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h55);
    send_frame("b2b_00", 0, 8'h00, 3, 1'b1);
    send_frame("b2b_ff", 0, 8'hFF, 2, 1'b1);
    send_frame("b2b_55", 0, 8'h55, 2, 1'b0);
    repeat (2) @(negedge clk);
    check("b2b_rd_cnt", 64'(rd_cnt_a), 64'(4));
    check("b2b_fd_cnt", 64'(fd_cnt_a), 64'(4));
    push(1, 8'h07);
    push(1, 8'h03);
    send_frame("par_07", 1, 8'h07, 3, 1'b1);
    send_frame("par_03", 1, 8'h03, 2, 1'b0);
    repeat (2) @(negedge clk);
    check("par_rd_cnt", 64'(rd_cnt_b), 64'(2));
    check("par_fd_cnt", 64'(fd_cnt_b), 64'(2));
    push(0, 8'hA5);
    push(0, 8'h3C);
    wait_low(0, k);
    check("abort_gap", 64'(k), 64'(3));
    repeat (17) @(negedge clk);
    check("abort_bit3", 64'(tx_a), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst", 64'({tx_a, busy_a, fd_a}), 64'(3'b100));
    rst = 1'b0;
    send_frame("after_3c", 0, 8'h3C, 3, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_rd_cnt", 64'(rd_cnt_a), 64'(6));
    check("abort_fd_cnt", 64'(fd_cnt_a), 64'(5));
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      bad |= ifa.fifo_rd_en | ~tx_a | busy_a;
    end
    check("idle_quiet", 64'(bad), 64'(0));
    check("idle_rd_cnt", 64'(rd_cnt_a), 64'(6));
    check("rd_protocol", 64'(viol), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
